// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants and enums for the VGA test-pattern scheduler
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_HGRAD = 2'd2,
        PAT_VGRAD = 2'd3
    } pat_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } state_e;

endpackage

// File: rtl/vga_pattern_sched_if.sv
// rtl/vga_pattern_sched_if.sv - timing, control and pin bundle of the pattern scheduler
interface vga_pattern_sched_if;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       display_on;
    logic       hsync_in;
    logic       vsync_in;
    logic       auto_en;
    logic       next_req;
    logic       next_ack;
    logic [1:0] pattern_sel;
    logic [3:0] VGA_R;
    logic [3:0] VGA_G;
    logic [3:0] VGA_B;
    logic       VGA_HS;
    logic       VGA_VS;

    modport master (
        output hpos, vpos, display_on, hsync_in, vsync_in, auto_en, next_req,
        input  next_ack, pattern_sel, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
    );

    modport slave (
        input  hpos, vpos, display_on, hsync_in, vsync_in, auto_en, next_req,
        output next_ack, pattern_sel, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - combinational map from pixel position and pattern to 12-bit RGB
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int BAR_WIDTH = 80
) (
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  pat_e        pattern_sel,
    output logic [11:0] rgb
);

    logic [9:0] bar_idx;
    logic [2:0] bar_c;
    logic       unused_bits;

    assign bar_idx     = hpos / 10'(BAR_WIDTH);
    assign bar_c       = 3'd7 - bar_idx[2:0];
    assign unused_bits = &{1'b0, bar_idx[9:3], vpos[9], vpos[4:0]};

    always_comb begin
        rgb = '0;
        case (pattern_sel)
            PAT_BARS:  rgb = {{4{bar_c[2]}}, {4{bar_c[1]}}, {4{bar_c[0]}}};
            PAT_CHECK: rgb = {12{hpos[5] ^ vpos[5]}};
            PAT_HGRAD: rgb = {hpos[9:6], hpos[9:6], hpos[9:6]};
            PAT_VGRAD: rgb = {8'h00, vpos[8:5]};
            default:   rgb = '0;
        endcase
    end

endmodule

// File: rtl/vga_pattern_sched.sv
// rtl/vga_pattern_sched.sv - tear-free test-pattern scheduler with registered RGB and syncs
module vga_pattern_sched
    import vga_pkg::*;
#(
    parameter int BAR_WIDTH          = 80,
    parameter int FRAMES_PER_PATTERN = 60
) (
    input  logic                clk,
    input  logic                reset,
    vga_pattern_sched_if.slave  bus
);

    localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_PATTERN - 1);

    state_e      state;
    pat_e        pat;
    logic [7:0]  frame_cnt;
    logic        next_ack_q;
    logic [11:0] gen_rgb;
    logic [11:0] rgb_q;
    logic        hs_q;
    logic        vs_q;
    logic        fb;
    logic        auto_hit;
    logic        manual_hit;

    vga_pattern_gen #(.BAR_WIDTH(BAR_WIDTH)) u_gen (
        .hpos        (bus.hpos),
        .vpos        (bus.vpos),
        .pattern_sel (pat),
        .rgb         (gen_rgb)
    );

    // First cycle of vertical blanking: the only point where the pattern may change.
    assign fb         = (bus.vpos == 10'(V_ACTIVE)) && (bus.hpos == 10'd0);
    assign auto_hit   = fb && bus.auto_en && (frame_cnt == CNT_LAST);
    assign manual_hit = fb && (state == ST_PEND);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_RUN;
            pat        <= PAT_BARS;
            frame_cnt  <= '0;
            next_ack_q <= 1'b0;
            rgb_q      <= '0;
            hs_q       <= 1'b1;
            vs_q       <= 1'b1;
        end else begin
            next_ack_q <= manual_hit;
            case (state)
                // A request still high during the ack cycle belongs to the one just served.
                ST_RUN:  if (bus.next_req && !next_ack_q) state <= ST_PEND;
                ST_PEND: if (fb) state <= ST_RUN;
                default: state <= ST_RUN;
            endcase
            if (auto_hit || manual_hit) begin
                pat <= pat_e'(pat + 2'd1);
            end
            if (!bus.auto_en || auto_hit || manual_hit) begin
                frame_cnt <= '0;
            end else if (fb) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            rgb_q <= bus.display_on ? gen_rgb : 12'h000;
            hs_q  <= bus.hsync_in;
            vs_q  <= bus.vsync_in;
        end
    end

    assign bus.next_ack    = next_ack_q;
    assign bus.pattern_sel = pat;
    assign bus.VGA_R       = rgb_q[11:8];
    assign bus.VGA_G       = rgb_q[7:4];
    assign bus.VGA_B       = rgb_q[3:0];
    assign bus.VGA_HS      = hs_q;
    assign bus.VGA_VS      = vs_q;

endmodule
